cl_seq_divider: RTL and testbench
=================================

# cl_seq_divider

Iterative divider, the inverse companion of the team's carry-less multiplier and adder datapath. Computes quotient and remainder of two DATA_WIDTH operands, one quotient bit per cycle, MSB first. Runs either as integer restoring division or as GF(2) polynomial (carry-less) division, selected per operation by `carry_option`. Used wherever products from the carry-less multiplier need reducing or checking.

## Interface
- `DATA_WIDTH`, 32, operand/result width (≥2)
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  request; accepted only when `busy`=0
- `carry_option`  in  1  1 = integer division, 0 = carry-less division; sampled with `start`
- `dividend`  in  DATA_WIDTH  sampled with accepted `start`
- `divisor`  in  DATA_WIDTH  sampled with accepted `start`
- `busy`  out  1  operation in progress
- `done`  out  1  one-cycle pulse, results valid
- `quotient`  out  DATA_WIDTH  held until next accepted `start`
- `remainder`  out  DATA_WIDTH  held until next accepted `start`
- `div_by_zero`  out  1  set with `done` when divisor was 0; held like results

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE; all outputs 0.
- IDLE/DONE + `start`: latch operands and mode, clear partial remainder R (DATA_WIDTH+1 bits) and quotient, load counter = DATA_WIDTH-1 → RUN. Divisor 0 → DONE directly.
- RUN, each cycle: R = {R[DATA_WIDTH-1:0], next dividend bit (MSB first)}.
  - Integer: subtract divisor via sub-module; no borrow → R = difference, q bit = 1; else q bit = 0, R unchanged.
  - Carry-less: bit of R at position deg(divisor) (MSB index, computed at accept) set → R = R XOR divisor, q bit = 1; else 0.
  - Counter 0 → DONE, else decrement.
- DONE: `done`=1 for one cycle, results registered; next cycle → IDLE unless `start` accepted.
- Divide by zero: `quotient`=all ones, `remainder`=dividend, `div_by_zero`=1.
- `start` while `busy`: ignored, no effect on running operation or latched operands.
- `rst` mid-operation: immediate return to IDLE; outputs 0; no `done`.

## Timing
- `start` sampled at edge N → `busy`=1 from N+1 through the iteration edge N+DATA_WIDTH; `done`=1, `busy`=0 in cycle after edge N+DATA_WIDTH.
- Divisor 0: `done` in cycle after edge N; `busy` never asserted.
- `start` during the `done` cycle accepted: back-to-back throughput one result per DATA_WIDTH+1 cycles.
- Results and `div_by_zero` change only at `done` or reset.

## Configuration
- `CL_DIV_INT_MODE_EN` defined: both modes available, integer subtractor instantiated.
- Undefined: `carry_option` ignored (port kept), always carry-less; subtractor omitted, XOR path only.

## Structure
- Package `cl_div_pkg`: state enum (IDLE/RUN/DONE), default width constant, counter-width function ($clog2(DATA_WIDTH)), MSB-index function.
- Sub-module `cl_rca_subtractor` (DATA_WIDTH+1): `carry_option`, a, b → diff, borrow; with `carry_option`=0 diff = a XOR b, borrow = 0.

## Test plan
- DATA_WIDTH=8, integer, 100/7 → q=14, r=2, `done` 8 cycles after start edge.
- Carry-less 0x57/0x0B → q=0x09, r=0x04 (check: 0x0B⊗0x09 ⊕ 0x04 = 0x57).
- Divisor 0, dividend 0x5A → `done` next cycle, q=0xFF, r=0x5A, `div_by_zero`=1; subsequent 9/3 clears it (q=3, r=0).
- Edges: integer 3/200 → q=0, r=3; integer 0xFF/0x01 → q=0xFF, r=0; carry-less 0xFF/0x01 → q=0xFF, r=0.
- `start` with new operands pulsed at cycle 3 of RUN → ignored, original result unchanged; `start` in `done` cycle → second result 8 cycles later.
- `rst` at cycle 4 of RUN → outputs 0, no `done`, IDLE; fresh start completes normally.

Source files
------------

// File: rtl/cl_div_pkg.sv
// Shared types and helpers for the cl_seq_divider iterative divider.
package cl_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 32;
  localparam int MAX_WIDTH     = 128;

  function automatic int cnt_width(input int width);
    int w;
    if (width > 2) begin
      w = $clog2(width);
    end else begin
      w = 1;
    end
    return w;
  endfunction

  // Index of the highest set bit; 0 for a zero input.
  function automatic int msb_index(input logic [MAX_WIDTH-1:0] value);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (value[i]) begin
        idx = i;
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/cl_rca_subtractor.sv
// Ripple-borrow subtractor; with i_carry_option=0 it degenerates to a plain XOR.
module cl_rca_subtractor
  import cl_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH + 1
) (
  input  logic             i_carry_option,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow
);

  logic [WIDTH:0] w_brw;

  // Bitwise full-subtractor chain, borrow propagation gated by the mode.
  always_comb begin
    w_brw    = '0;
    o_diff   = i_a ^ i_b;
    for (int i = 0; i < WIDTH; i++) begin
      o_diff[i]    = i_a[i] ^ i_b[i] ^ w_brw[i];
      w_brw[i + 1] = i_carry_option &
                     ((~i_a[i] & i_b[i]) | (~(i_a[i] ^ i_b[i]) & w_brw[i]));
    end
    o_borrow = w_brw[WIDTH];
  end

endmodule

// File: rtl/cl_seq_divider.sv
// Iterative integer / carry-less divider, one quotient bit per cycle, MSB first.
// Integer mode only exists when CL_DIV_INT_MODE_EN is defined; otherwise always carry-less.
module cl_seq_divider
  import cl_div_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_carry_option,
  input  logic [DATA_WIDTH-1:0] i_dividend,
  input  logic [DATA_WIDTH-1:0] i_divisor,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_quotient,
  output logic [DATA_WIDTH-1:0] o_remainder,
  output logic                  o_div_by_zero
);

  localparam int CW = cnt_width(DATA_WIDTH);
  localparam int DW = $clog2(DATA_WIDTH + 1);
  localparam int RW = DATA_WIDTH + 1;

  state_t                r_state;
  state_t                w_next_state;
  logic [CW-1:0]         r_cnt;
  logic [RW-1:0]         r_rem;
  logic [DATA_WIDTH-1:0] r_quo;
  logic [DATA_WIDTH-1:0] r_dvd;
  logic [DATA_WIDTH-1:0] r_dvs;
  logic                  r_mode;
  logic [DW-1:0]         r_deg;

  logic                  r_busy;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_quotient;
  logic [DATA_WIDTH-1:0] r_remainder;
  logic                  r_dbz;

  logic                  w_accept;
  logic                  w_div_zero;
  logic                  w_last;
  logic                  w_mode_in;
  logic [MAX_WIDTH-1:0]  w_dvs_wide;
  logic [DW-1:0]         w_deg_in;
  logic [RW-1:0]         w_shift;
  logic [RW-1:0]         w_dvs_ext;
  logic [RW-1:0]         w_diff;
  logic                  w_borrow;
  logic                  w_take;
  logic [RW-1:0]         w_rem_nxt;
  logic [DATA_WIDTH-1:0] w_quo_nxt;

  assign w_accept   = i_start & (r_state != ST_RUN);
  assign w_div_zero = (i_divisor == {DATA_WIDTH{1'b0}});
  assign w_last     = (r_cnt == {CW{1'b0}});
  assign w_dvs_wide = MAX_WIDTH'(i_divisor);
  assign w_deg_in   = DW'(msb_index(w_dvs_wide));
  assign w_shift    = {r_rem[DATA_WIDTH-1:0], r_dvd[DATA_WIDTH-1]};
  assign w_dvs_ext  = {1'b0, r_dvs};

`ifdef CL_DIV_INT_MODE_EN
  assign w_mode_in = i_carry_option;

  cl_rca_subtractor #(
    .WIDTH(RW)
  ) u_sub (
    .i_carry_option(r_mode),
    .i_a           (w_shift),
    .i_b           (w_dvs_ext),
    .o_diff        (w_diff),
    .o_borrow      (w_borrow)
  );
`else
  logic w_unused_carry_option;
  assign w_unused_carry_option = i_carry_option;
  assign w_mode_in = 1'b0;
  assign w_diff    = w_shift ^ w_dvs_ext;
  assign w_borrow  = 1'b0;
`endif

  // Integer keeps the difference when no borrow; carry-less reduces when the degree bit is set.
  assign w_take    = r_mode ? ~w_borrow : w_shift[r_deg];
  assign w_rem_nxt = w_take ? w_diff : w_shift;
  assign w_quo_nxt = {r_quo[DATA_WIDTH-2:0], w_take};

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          if (w_div_zero) begin
            w_next_state = ST_DONE;
          end else begin
            w_next_state = ST_RUN;
          end
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_RUN;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Operand latch and iteration datapath.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvd  <= '0;
      r_dvs  <= '0;
      r_mode <= 1'b0;
      r_deg  <= '0;
    end else if (w_accept) begin
      r_cnt  <= CW'(DATA_WIDTH - 1);
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvd  <= i_dividend;
      r_dvs  <= i_divisor;
      r_mode <= w_mode_in;
      r_deg  <= w_deg_in;
    end else if (r_state == ST_RUN) begin
      r_cnt  <= r_cnt - CW'(1);
      r_rem  <= w_rem_nxt;
      r_quo  <= w_quo_nxt;
      r_dvd  <= {r_dvd[DATA_WIDTH-2:0], 1'b0};
    end
  end

  // Status flags and results; results move only when done is raised.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      r_busy <= (w_next_state == ST_RUN);
      r_done <= (w_next_state == ST_DONE);
      if (w_accept && w_div_zero) begin
        r_quotient  <= {DATA_WIDTH{1'b1}};
        r_remainder <= i_dividend;
        r_dbz       <= 1'b1;
      end else if ((r_state == ST_RUN) && w_last) begin
        r_quotient  <= w_quo_nxt;
        r_remainder <= w_rem_nxt[DATA_WIDTH-1:0];
        r_dbz       <= 1'b0;
      end
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_quotient    = r_quotient;
  assign o_remainder   = r_remainder;
  assign o_div_by_zero = r_dbz;

endmodule

// File: tb/tb_cl_seq_divider.sv
// Self-checking bench for cl_seq_divider (DATA_WIDTH=8): directed plan items plus random traffic.
module tb_cl_seq_divider;

  localparam int W = 8;
`ifdef CL_DIV_INT_MODE_EN
  localparam bit INT_EN = 1'b1;
`else
  localparam bit INT_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         copt = 1'b0;
  logic [W-1:0] dvd = '0;
  logic [W-1:0] dvs = '0;
  logic         busy, done, dbz;
  logic [W-1:0] quo, rem;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  cl_seq_divider #(.DATA_WIDTH(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_carry_option(copt),
    .i_dividend(dvd), .i_divisor(dvs),
    .o_busy(busy), .o_done(done), .o_quotient(quo), .o_remainder(rem),
    .o_div_by_zero(dbz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Textbook division: integer via / and %, polynomial via long division from the top degree.
  function automatic void ref_div(input bit m, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
    int db;
    q = '0;
    r = a;
    if (b == '0) begin
      q = '1;
    end else if (m) begin
      q = a / b;
      r = a % b;
    end else begin
      db = 0;
      for (int i = 0; i < W; i++) if (b[i]) db = i;
      for (int i = W - 1; i >= db; i--) begin
        if (r[i]) begin
          r = r ^ (b << (i - db));
          q[i - db] = 1'b1;
        end
      end
    end
  endfunction

  // Reference timeline: an accepted op keeps busy for W edges, then a one-cycle done.
  int           m_left = 0;
  logic         m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0, p_dbz = 1'b0;
  logic [W-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_left = 0; m_busy = 1'b0; m_done = 1'b0; m_dbz = 1'b0; m_q = '0; m_r = '0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0; m_done = 1'b1; m_q = p_q; m_r = p_r; m_dbz = p_dbz;
        end
      end else if (start) begin
        ref_div(copt & INT_EN, dvd, dvs, p_q, p_r);
        p_dbz = (dvs == '0);
        if (p_dbz) begin
          m_done = 1'b1; m_q = p_q; m_r = p_r; m_dbz = 1'b1;
        end else begin
          m_left = W; m_busy = 1'b1;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("cyc_busy", 32'(busy), 32'(m_busy));
      chk("cyc_done", 32'(done), 32'(m_done));
      chk("cyc_quotient", 32'(quo), 32'(m_q));
      chk("cyc_remainder", 32'(rem), 32'(m_r));
      chk("cyc_div_by_zero", 32'(dbz), 32'(m_dbz));
    end
  end

  task automatic start_op(input bit m, input logic [W-1:0] a, input logic [W-1:0] b);
    copt = m; dvd = a; dvs = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input bit m, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input bit edbz,
                        input int elat, input string nm);
    int lat;
    @(posedge clk); #1;
    start_op(m, a, b);
    wait_done(lat);
    chk({nm, "_done"}, 32'(done), 32'd1);
    chk({nm, "_lat"}, 32'(lat), 32'(elat));
    chk({nm, "_q"}, 32'(quo), 32'(eq));
    chk({nm, "_r"}, 32'(rem), 32'(er));
    chk({nm, "_dbz"}, 32'(dbz), 32'(edbz));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] q, r;
    int           lat;
    bit           seen;
    bit           m;
    logic [W-1:0] a, b;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_q", 32'(quo), 32'd0);
    chk("reset_r", 32'(rem), 32'd0);
    chk("reset_dbz", 32'(dbz), 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    ref_div(1'b1, 8'd100, 8'd7, q, r);
    chk("model_int_100_7", 32'({q, r}), 32'h0E02);
    ref_div(1'b0, 8'h57, 8'h0B, q, r);
    chk("model_cl_57_0b", 32'({q, r}), 32'h0904);
    ref_div(1'b0, 8'h09, 8'h03, q, r);
    chk("model_cl_9_3", 32'({q, r}), 32'h0700);
    ref_div(1'b1, 8'd3, 8'd200, q, r);
    chk("model_int_3_200", 32'({q, r}), 32'h0003);

`ifdef CL_DIV_INT_MODE_EN
    run_op(1'b1, 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, W, "int_100_7");
    run_op(1'b1, 8'd3, 8'd200, 8'd0, 8'd3, 1'b0, W, "int_3_200");
    run_op(1'b1, 8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0, W, "int_ff_1");
`endif
    run_op(1'b0, 8'h57, 8'h0B, 8'h09, 8'h04, 1'b0, W, "cl_57_0b");
    run_op(1'b0, 8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0, W, "cl_ff_1");
    run_op(1'b1, 8'h5A, 8'h00, 8'hFF, 8'h5A, 1'b1, 0, "div0");
`ifdef CL_DIV_INT_MODE_EN
    run_op(1'b1, 8'd9, 8'd3, 8'd3, 8'd0, 1'b0, W, "after_div0");
`else
    run_op(1'b1, 8'd9, 8'd3, 8'd7, 8'd0, 1'b0, W, "after_div0");
`endif

    // A start pulse in the middle of a run must not disturb it.
    @(posedge clk); #1;
    start_op(1'b0, 8'h57, 8'h0B);
    repeat (2) begin @(posedge clk); #1; end
    copt = 1'b1; dvd = 8'h33; dvs = 8'h05; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
    chk("ignored_lat", 32'(lat + 3), 32'(W));
    chk("ignored_q", 32'(quo), 32'h09);
    chk("ignored_r", 32'(rem), 32'h04);

    // Back-to-back: start issued during the done cycle.
    start_op(1'b0, 8'hFF, 8'h01);
    wait_done(lat);
    chk("b2b_lat", 32'(lat), 32'(W));
    chk("b2b_q", 32'(quo), 32'hFF);
    chk("b2b_r", 32'(rem), 32'h00);

    // Reset in the middle of a run.
    @(posedge clk); #1;
    start_op(1'b0, 8'h57, 8'h0B);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_q", 32'(quo), 32'd0);
    chk("midrst_r", 32'(rem), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (W + 3) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk("midrst_no_done", 32'(seen), 32'd0);
    run_op(1'b0, 8'h57, 8'h0B, 8'h09, 8'h04, 1'b0, W, "after_rst");

    // Random traffic, checked cycle by cycle against the reference timeline.
    for (int k = 0; k < 150; k++) begin
      m = 1'($urandom_range(0, 1));
      a = W'($urandom);
      if ($urandom_range(0, 7) == 0) b = '0;
      else if ($urandom_range(0, 1) == 1) b = W'($urandom_range(1, 15));
      else b = W'($urandom);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      start_op(m, a, b);
      if (b != '0 && $urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(1, 5)) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
      end else begin
        if (b != '0 && $urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 4)) begin @(posedge clk); #1; end
          copt = 1'($urandom_range(0, 1)); dvd = W'($urandom); dvs = W'($urandom);
          start = 1'b1;
          @(posedge clk); #1;
          start = 1'b0;
        end
        wait_done(lat);
        chk("rand_done_seen", 32'(done), 32'd1);
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
